// File: rtl/udp_rx_frame_extractor.sv
// ---------------------------------------------------------------------------
// udp_rx_frame_extractor
//
// Sits between a 32-bit Avalon-ST MAC receive port (shift16 mode) and two
// downstream FIFOs. It parses the Ethernet/IPv4/UDP headers of each frame,
// forwards only the UDP payload words to the data FIFO, and at end of frame
// writes the payload byte count to the descriptor FIFO and pulses int_rsv.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   rx_data         : frame word, first wire byte in [31:24]
//   rx_sop/rx_eop   : frame delimiters, qualified by rx_dval
//   rx_dval         : word valid
//   rx_rdy          : sink ready (high every cycle after reset)
//   rx_err          : MAC error flags, meaningful on the eop word
//   rx_mod          : empty bytes in the eop word
//   rx_dsav, rx_err_stat, rx_frm_type, rx_a_full, rx_a_empty : unused
//   data_to_mem     : payload word, valid with wren_mem
//   wren_mem        : data FIFO write strobe (one cycle after the input word)
//   size            : payload byte count, valid with desc_wr, then held
//   desc_wr         : descriptor FIFO write strobe
//   int_rsv         : frame-received pulse, coincident with desc_wr
//   stat_err        : [31:24] dropped-frame count, [23:8] accepted-frame
//                     count, [7] runt/aborted, [6] length mismatch,
//                     [5:0] MAC error flags of the last frame
// ---------------------------------------------------------------------------
module udp_rx_frame_extractor #(
    parameter logic [15:0] UDP_DST_PORT = 16'h0000,
    parameter int          PAD_BYTES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_data,
    input  logic        rx_sop,
    input  logic        rx_eop,
    output logic        rx_rdy,
    input  logic        rx_dval,
    input  logic        rx_dsav,
    input  logic [5:0]  rx_err,
    input  logic [17:0] rx_err_stat,
    input  logic [3:0]  rx_frm_type,
    input  logic [1:0]  rx_mod,
    input  logic        rx_a_full,
    input  logic        rx_a_empty,
    output logic [31:0] data_to_mem,
    output logic [31:0] stat_err,
    output logic        wren_mem,
    output logic [15:0] size,
    output logic        int_rsv,
    output logic        desc_wr
);

    // pad + Ethernet(14) + IPv4 without options(20) + UDP(8) bytes
    localparam int          HDR_WORDS = (PAD_BYTES + 14 + 20 + 8) / 4;
    localparam logic [15:0] LAST_HDR  = 16'(HDR_WORDS - 1);

    localparam logic [15:0] WC_ETYPE = 16'd3;
    localparam logic [15:0] WC_IPVER = 16'd4;
    localparam logic [15:0] WC_PROTO = 16'd6;
    localparam logic [15:0] WC_PORTS = 16'd9;
    localparam logic [15:0] WC_ULEN  = 16'd10;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t      state, state_nxt;
    logic [15:0] wc, wc_nxt;        // index of the next expected word
    logic [15:0] pw, pw_nxt;        // payload words written this frame
    logic [15:0] ulen, ulen_nxt;
    logic [15:0] iplen, iplen_nxt;
    logic [7:0]  drop_cnt, drop_cnt_nxt;
    logic [15:0] acc_cnt, acc_cnt_nxt;
    logic [7:0]  flags, flags_nxt;
    logic [31:0] data_nxt;
    logic        wren_nxt;
    logic        desc_nxt;
    logic [15:0] size_nxt;

    logic [15:0] idx;
    logic        start;
    logic        hdr_word;
    logic        hdr_ok;
    logic [15:0] pw_inc;
    logic [15:0] close_size;
    logic [15:0] eop_size;

    // IP total length is captured for the host view but nothing consumes it
    logic unused_ok;
    assign unused_ok = &{1'b0, rx_dsav, rx_err_stat, rx_frm_type,
                         rx_a_full, rx_a_empty, iplen};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign stat_err = {drop_cnt, acc_cnt, flags};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wc          <= '0;
            pw          <= '0;
            ulen        <= '0;
            iplen       <= '0;
            drop_cnt    <= '0;
            acc_cnt     <= '0;
            flags       <= '0;
            data_to_mem <= '0;
            wren_mem    <= 1'b0;
            desc_wr     <= 1'b0;
            int_rsv     <= 1'b0;
            size        <= '0;
            rx_rdy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            wc          <= wc_nxt;
            pw          <= pw_nxt;
            ulen        <= ulen_nxt;
            iplen       <= iplen_nxt;
            drop_cnt    <= drop_cnt_nxt;
            acc_cnt     <= acc_cnt_nxt;
            flags       <= flags_nxt;
            data_to_mem <= data_nxt;
            wren_mem    <= wren_nxt;
            desc_wr     <= desc_nxt;
            int_rsv     <= desc_nxt;
            size        <= size_nxt;
            rx_rdy      <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wc_nxt       = wc;
        pw_nxt       = pw;
        ulen_nxt     = ulen;
        iplen_nxt    = iplen;
        drop_cnt_nxt = drop_cnt;
        acc_cnt_nxt  = acc_cnt;
        flags_nxt    = flags;
        data_nxt     = data_to_mem;
        wren_nxt     = 1'b0;
        desc_nxt     = 1'b0;
        size_nxt     = size;

        // a DROP frame ignores everything up to its eop, sop included
        start      = rx_sop && (state != DROP);
        idx        = start ? 16'd0 : wc;
        hdr_word   = start || (state == HDR);
        pw_inc     = sat_inc(pw);
        close_size = {pw[13:0], 2'b00};
        eop_size   = {pw_inc[13:0], 2'b00} - {14'd0, rx_mod};

        hdr_ok = 1'b1;
        case (idx)
            WC_ETYPE: hdr_ok = (rx_data[15:0] == 16'h0800);
            WC_IPVER: hdr_ok = (rx_data[31:24] == 8'h45);
            WC_PROTO: hdr_ok = (rx_data[23:16] == 8'h11);
            WC_PORTS: hdr_ok = (UDP_DST_PORT == 16'h0000) ||
                               (rx_data[15:0] == UDP_DST_PORT);
            default:  hdr_ok = 1'b1;
        endcase

        if (rx_dval) begin
            // sop inside a payload: close the open frame with what was
            // already written so the two FIFOs stay in step
            if (rx_sop && state == PAYLOAD) begin
                size_nxt  = close_size;
                desc_nxt  = 1'b1;
                flags_nxt = {1'b1, close_size != (ulen - 16'd8), 6'd0};
            end

            if (start) begin
                pw_nxt    = '0;
                state_nxt = HDR;
            end

            if (hdr_word) begin
                wc_nxt = sat_inc(idx);
                if (idx == WC_IPVER) iplen_nxt = rx_data[15:0];
                if (idx == WC_ULEN)  ulen_nxt  = rx_data[31:16];
                if (rx_eop) begin
                    // runt: frame ended before any payload
                    flags_nxt    = {1'b1, 1'b0, rx_err};
                    drop_cnt_nxt = drop_cnt + 8'd1;
                    state_nxt    = IDLE;
                end else if (!hdr_ok) begin
                    drop_cnt_nxt = drop_cnt + 8'd1;
                    state_nxt    = DROP;
                end else if (idx == LAST_HDR) begin
                    state_nxt = PAYLOAD;
                end
            end else begin
                case (state)
                    PAYLOAD: begin
                        wc_nxt   = sat_inc(wc);
                        pw_nxt   = pw_inc;
                        data_nxt = rx_data;
                        wren_nxt = 1'b1;
                        if (rx_eop) begin
                            size_nxt    = eop_size;
                            desc_nxt    = 1'b1;
                            flags_nxt   = {1'b0, eop_size != (ulen - 16'd8), rx_err};
                            acc_cnt_nxt = acc_cnt + 16'd1;
                            state_nxt   = IDLE;
                        end
                    end
                    DROP: begin
                        if (rx_eop) state_nxt = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_frame_extractor.sv
`timescale 1ns/1ps
module tb_udp_rx_frame_extractor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_data;
    logic        rx_sop, rx_eop, rx_dval, rx_dsav;
    logic [5:0]  rx_err;
    logic [17:0] rx_err_stat;
    logic [3:0]  rx_frm_type;
    logic [1:0]  rx_mod;
    logic        rx_a_full, rx_a_empty;
    logic        rx_rdy;
    logic [31:0] data_to_mem, stat_err;
    logic        wren_mem, int_rsv, desc_wr;
    logic [15:0] size;

    always #5 clk = ~clk;

    udp_rx_frame_extractor #(.UDP_DST_PORT(16'h0000), .PAD_BYTES(2)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_rdy(rx_rdy), .rx_dval(rx_dval), .rx_dsav(rx_dsav), .rx_err(rx_err),
        .rx_err_stat(rx_err_stat), .rx_frm_type(rx_frm_type), .rx_mod(rx_mod),
        .rx_a_full(rx_a_full), .rx_a_empty(rx_a_empty), .data_to_mem(data_to_mem),
        .stat_err(stat_err), .wren_mem(wren_mem), .size(size), .int_rsv(int_rsv),
        .desc_wr(desc_wr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] fw [0:63];
    int          drv_cyc [0:63];

    logic [31:0] got_data[$];
    int          got_cyc[$];
    logic [15:0] got_size[$];
    logic [31:0] got_stat[$];
    logic [31:0] exp_data[$];
    int          exp_cyc[$];
    logic [15:0] exp_size[$];
    logic [7:0]  exp_flags[$];
    logic [7:0]  exp_fmask[$];

    // reference state: counters and low status byte as the host should see them
    logic [7:0]  m_drop  = 0;
    logic [15:0] m_acc   = 0;
    logic [7:0]  m_flags = 0;
    logic [7:0]  m_fmask = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wren_mem) begin
                got_data.push_back(data_to_mem);
                got_cyc.push_back(cyc);
            end
            if (desc_wr) begin
                got_size.push_back(size);
                got_stat.push_back(stat_err);
            end
            if (desc_wr || int_rsv)
                chk("int_rsv_vs_desc_wr", 32'(int_rsv), 32'(desc_wr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [15:0] et, input logic [7:0] ver,
                         input logic [7:0] proto, input logic [15:0] ulen);
        for (int i = 0; i < 64; i++) fw[i] = $urandom;
        fw[3][15:0]  = et;
        fw[4][31:24] = ver;
        fw[6][23:16] = proto;
        fw[10][31:16] = ulen;
    endtask

    // idle gaps carry random data and delimiters with dval low
    task automatic drive_frame(input int n, input bit with_eop, input logic [1:0] mod,
                               input logic [5:0] err, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            int gaps = 0;
            while (gaps < 4 && $urandom_range(99) < gap_pct) begin
                rx_dval = 1'b0;
                rx_data = $urandom;
                rx_sop  = 1'($urandom);
                rx_eop  = 1'($urandom);
                tick();
                gaps++;
            end
            rx_dval = 1'b1;
            rx_data = fw[i];
            rx_sop  = (i == 0);
            rx_eop  = with_eop && (i == n - 1);
            rx_mod  = rx_eop ? mod : 2'($urandom);
            rx_err  = rx_eop ? err : 6'($urandom);
            drv_cyc[i] = cyc;
            tick();
        end
        rx_dval = 1'b0;
        rx_sop  = 1'b0;
        rx_eop  = 1'b0;
    endtask

    // Frame-level reference: words 0..10 are headers, the rest is payload.
    task automatic model_frame(input int n, input logic [1:0] mod, input logic [5:0] err);
        int e, f;
        logic [15:0] sz, ul;
        e = n - 1;
        f = 99;
        if (fw[3][15:0] != 16'h0800)       f = 3;
        else if (fw[4][31:24] != 8'h45)    f = 4;
        else if (fw[6][23:16] != 8'h11)    f = 6;
        ul = fw[10][31:16];
        if (e <= 10 && f >= e) begin
            m_drop  = m_drop + 8'd1;
            m_flags = {1'b1, 1'b0, err};
            m_fmask = 8'h80;
        end else if (f <= 10) begin
            m_drop = m_drop + 8'd1;
        end else begin
            for (int i = 11; i <= e; i++) begin
                exp_data.push_back(fw[i]);
                exp_cyc.push_back(drv_cyc[i] + 1);
            end
            sz = 16'((e - 10) * 4) - {14'd0, mod};
            m_flags = {1'b0, sz != ul - 16'd8, err};
            m_fmask = 8'hFF;
            m_acc   = m_acc + 16'd1;
            exp_size.push_back(sz);
            exp_flags.push_back(m_flags);
            exp_fmask.push_back(8'hFF);
        end
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_wr_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk({tag, "_wr_data"}, got_data[i], exp_data[i]);
            chk({tag, "_wr_cycle"}, got_cyc[i], exp_cyc[i]);
        end
        chk({tag, "_desc_count"}, got_size.size(), exp_size.size());
        for (int i = 0; i < exp_size.size() && i < got_size.size(); i++) begin
            chk({tag, "_desc_size"}, got_size[i], exp_size[i]);
            chk({tag, "_desc_flags"}, got_stat[i][7:0] & exp_fmask[i], exp_flags[i] & exp_fmask[i]);
        end
        chk({tag, "_stat_cnt"}, {8'h0, stat_err[31:8]}, {8'h0, m_drop, m_acc});
        chk({tag, "_stat_flags"}, stat_err[7:0] & m_fmask, m_flags & m_fmask);
        got_data.delete(); got_cyc.delete(); got_size.delete(); got_stat.delete();
        exp_data.delete(); exp_cyc.delete(); exp_size.delete(); exp_flags.delete(); exp_fmask.delete();
    endtask

    typedef struct {
        int          n;
        logic [15:0] et;
        logic [7:0]  ver;
        logic [7:0]  proto;
        logic [15:0] ulen;
        logic [1:0]  mod;
        logic [5:0]  err;
        int          gap;
        int          ex_wr;
        int          ex_desc;
        logic [15:0] ex_size;
        logic [7:0]  ex_flags;
        logic [7:0]  ex_fmask;
        int          ex_drop;
    } vec_t;

    vec_t        tv [9];
    logic [7:0]  d0;
    logic [15:0] a0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tv[0] = '{28, 16'h0800, 8'h45, 8'h11, 16'd76, 2'd0, 6'h00,  0, 17, 1, 16'd68, 8'h00, 8'hFF, 0};
        tv[1] = '{24, 16'h0800, 8'h45, 8'h11, 16'd76, 2'd0, 6'h05,  0, 13, 1, 16'd52, 8'h45, 8'hFF, 0};
        tv[2] = '{28, 16'h0800, 8'h45, 8'h11, 16'd74, 2'd2, 6'h00, 40, 17, 1, 16'd66, 8'h00, 8'hFF, 0};
        tv[3] = '{28, 16'h0806, 8'h45, 8'h11, 16'd76, 2'd0, 6'h00,  0,  0, 0, 16'd0,  8'h00, 8'h00, 1};
        tv[4] = '{28, 16'h0800, 8'h45, 8'h06, 16'd76, 2'd0, 6'h00,  0,  0, 0, 16'd0,  8'h00, 8'h00, 1};
        tv[5] = '{ 6, 16'h0800, 8'h45, 8'h11, 16'd76, 2'd0, 6'h00,  0,  0, 0, 16'd0,  8'h80, 8'h80, 1};
        tv[6] = '{11, 16'h0800, 8'h45, 8'h11, 16'd76, 2'd0, 6'h00,  0,  0, 0, 16'd0,  8'h80, 8'h80, 1};
        tv[7] = '{12, 16'h0800, 8'h45, 8'h11, 16'd9,  2'd3, 6'h3F, 20,  1, 1, 16'd1,  8'h3F, 8'hFF, 0};
        tv[8] = '{28, 16'h0800, 8'h46, 8'h11, 16'd76, 2'd0, 6'h00,  0,  0, 0, 16'd0,  8'h00, 8'h00, 1};

        rst = 1'b1; rx_data = '0; rx_sop = 0; rx_eop = 0; rx_dval = 0; rx_dsav = 0;
        rx_err = '0; rx_err_stat = '0; rx_frm_type = '0; rx_mod = '0;
        rx_a_full = 0; rx_a_empty = 0;

        // reset and idle
        tick();
        chk("rst_rdy", rx_rdy, 0);
        chk("rst_stat", stat_err, 0);
        chk("rst_wren", wren_mem, 0);
        chk("rst_desc", {desc_wr, int_rsv}, 0);
        chk("rst_size", size, 0);
        chk("rst_data", data_to_mem, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_rdy", rx_rdy, 1);
            chk("idle_strobes", {wren_mem, desc_wr, int_rsv}, 0);
        end
        chk("idle_stat", stat_err, 0);

        // table-driven frames
        for (int k = 0; k < 9; k++) begin
            d0 = stat_err[31:24];
            a0 = stat_err[23:8];
            build(tv[k].et, tv[k].ver, tv[k].proto, tv[k].ulen);
            drive_frame(tv[k].n, 1'b1, tv[k].mod, tv[k].err, tv[k].gap);
            model_frame(tv[k].n, tv[k].mod, tv[k].err);
            tick(); tick(); tick();
            chk("tv_writes", got_data.size(), tv[k].ex_wr);
            chk("tv_desc", got_size.size(), tv[k].ex_desc);
            if (tv[k].ex_desc > 0 && got_size.size() > 0)
                chk("tv_size", got_size[0], tv[k].ex_size);
            if (tv[k].ex_fmask != 8'h00)
                chk("tv_flags", stat_err[7:0] & tv[k].ex_fmask, tv[k].ex_flags & tv[k].ex_fmask);
            chk("tv_drop_inc", 8'(stat_err[31:24] - d0), tv[k].ex_drop);
            chk("tv_acc_inc", 16'(stat_err[23:8] - a0), tv[k].ex_desc);
            sb_check("tv");
        end

        // sop inside a payload: frame A (words 11..19 written) is closed by B's sop
        build(16'h0800, 8'h45, 8'h11, 16'd76);
        drive_frame(20, 1'b0, 2'd0, 6'd0, 0);
        for (int i = 11; i < 20; i++) begin
            exp_data.push_back(fw[i]);
            exp_cyc.push_back(drv_cyc[i] + 1);
        end
        exp_size.push_back(16'd36);
        exp_flags.push_back(8'h80);
        exp_fmask.push_back(8'h80);
        build(16'h0800, 8'h45, 8'h11, 16'd76);
        drive_frame(28, 1'b1, 2'd0, 6'd0, 0);
        model_frame(28, 2'd0, 6'd0);
        tick(); tick();
        sb_check("sop_in_payload");

        // reset mid-header: the tail of the frame must be ignored
        build(16'h0800, 8'h45, 8'h11, 16'd76);
        drive_frame(8, 1'b0, 2'd0, 6'd0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_drop = 0; m_acc = 0; m_flags = 0; m_fmask = 0;
        for (int i = 8; i < 28; i++) begin
            rx_dval = 1'b1; rx_data = fw[i]; rx_sop = 1'b0; rx_eop = (i == 27); rx_mod = 2'd0;
            tick();
        end
        rx_dval = 1'b0; rx_eop = 1'b0;
        tick(); tick();
        chk("rst_mid_stat", stat_err, 0);
        sb_check("rst_mid");

        // randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            int          n;
            logic [1:0]  mod;
            logic [5:0]  err;
            logic [15:0] et, ul;
            logic [7:0]  ver, proto;
            n     = $urandom_range(4, 40);
            mod   = 2'($urandom);
            err   = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0;
            et    = ($urandom_range(7) == 0) ? 16'h86DD : 16'h0800;
            ver   = ($urandom_range(7) == 0) ? 8'h46 : 8'h45;
            proto = ($urandom_range(7) == 0) ? 8'h06 : 8'h11;
            ul    = ($urandom_range(1) == 0) ? 16'((n - 11) * 4 - int'(mod) + 8) : 16'($urandom);
            build(et, ver, proto, ul);
            drive_frame(n, 1'b1, mod, err, $urandom_range(0, 40));
            model_frame(n, mod, err);
            if ($urandom_range(3) == 0) begin
                rx_dval = 1'b1; rx_sop = 1'b0; rx_eop = 1'($urandom); rx_data = $urandom;
                tick();
                rx_dval = 1'b0; rx_eop = 1'b0;
            end
            tick(); tick();
            sb_check("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
